// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
//   Shared pipeline constants for the decode-stage register file: default
//   widths, the register-address type, the hard-wired zero register index
//   and a helper returning the saturation value of a pending counter.
//   No ports (package).
// ---------------------------------------------------------------------------
package register_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_ADDR_W = $clog2(DEF_NREGS);
    localparam int DEF_PEND_W = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    localparam int ZERO_REG_IDX = 0;

    // Largest count a pending counter of the given width can hold.
    function automatic int pendMax(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// ---------------------------------------------------------------------------
// register_file_if
//   Bundles the decode-side read/issue signals and the writeback port of the
//   register file.
//   master : decode + writeback (drives addresses, strobes and write data)
//   slave  : register_file (returns read data, issue_ready and stall)
//   Signals: rd_addr_a/b, use_a/b, bus_a/b, wr_en, wr_addr, wr_data,
//            issue_en, issue_addr, issue_ready, stall
// ---------------------------------------------------------------------------
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              use_a;
    logic              use_b;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_ready;
    logic              stall;

    modport master (
        output rd_addr_a, rd_addr_b, use_a, use_b,
        output wr_en, wr_addr, wr_data,
        output issue_en, issue_addr,
        input  bus_a, bus_b, issue_ready, stall
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, use_a, use_b,
        input  wr_en, wr_addr, wr_data,
        input  issue_en, issue_addr,
        output bus_a, bus_b, issue_ready, stall
    );

endinterface

// File: rtl/pending_scoreboard.sv
// ---------------------------------------------------------------------------
// pending_scoreboard
//   One saturating pending-write counter per architectural register. Issue
//   increments the destination's counter, writeback decrements it (never
//   below zero). Generates issue_ready (counter not saturated) and stall
//   (an in-use operand still has an outstanding write after this cycle's
//   writeback is accounted for).
//   Ports: clk, rst_n (sync, active-low), i_wr_en, i_wr_addr, i_issue_en,
//          i_issue_addr, i_rd_addr_a/b, i_use_a/b, o_issue_ready, o_stall
// ---------------------------------------------------------------------------
module pending_scoreboard
    import register_file_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int PEND_W   = DEF_PEND_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_issue_en,
    input  logic [ADDR_W-1:0] i_issue_addr,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    input  logic              i_use_a,
    input  logic              i_use_b,
    output logic              o_issue_ready,
    output logic              o_stall
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pendMax(PEND_W));
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

    logic [PEND_W-1:0] r_cnt     [NREGS];
    logic [PEND_W-1:0] w_cntNext [NREGS];
    logic [NREGS-1:0]  w_incVec;
    logic [NREGS-1:0]  w_decVec;
    logic [PEND_W-1:0] w_effA;
    logic [PEND_W-1:0] w_effB;
    logic              w_zeroA;
    logic              w_zeroB;

    // A saturated destination can still accept an issue if the same cycle's
    // writeback retires one of its outstanding writes.
    always_comb begin
        o_issue_ready = (r_cnt[i_issue_addr] != CNT_MAX) || w_decVec[i_issue_addr];
    end

    always_comb begin
        w_incVec = '0;
        w_decVec = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_incVec[i]  = i_issue_en && o_issue_ready && (i_issue_addr == ADDR_W'(i));
            w_decVec[i]  = i_wr_en && (i_wr_addr == ADDR_W'(i)) && (r_cnt[i] != '0);
            w_cntNext[i] = r_cnt[i];
            if (ZERO_REG && (i == ZERO_REG_IDX)) begin
                w_cntNext[i] = '0;
            end else if (w_incVec[i] && !w_decVec[i]) begin
                w_cntNext[i] = r_cnt[i] + PEND_W'(1);
            end else if (w_decVec[i] && !w_incVec[i]) begin
                w_cntNext[i] = r_cnt[i] - PEND_W'(1);
            end
        end
    end

    // Effective pending count discounts a writeback landing this cycle, so
    // an operand being written back right now does not stall decode.
    always_comb begin
        w_effA  = r_cnt[i_rd_addr_a] - PEND_W'(w_decVec[i_rd_addr_a]);
        w_effB  = r_cnt[i_rd_addr_b] - PEND_W'(w_decVec[i_rd_addr_b]);
        w_zeroA = ZERO_REG && (i_rd_addr_a == ZERO_ADDR);
        w_zeroB = ZERO_REG && (i_rd_addr_b == ZERO_ADDR);
        o_stall = (i_use_a && !w_zeroA && (w_effA != '0)) ||
                  (i_use_b && !w_zeroB && (w_effB != '0));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rst_n) begin
                r_cnt[i] <= '0;
            end else begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

    // Counters must never wrap in either direction; register 0 stays idle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                assert (!(w_incVec[i] && !w_decVec[i] && (r_cnt[i] == CNT_MAX)));
                assert (!(w_decVec[i] && !w_incVec[i] && (r_cnt[i] == '0)));
            end
            assert (!ZERO_REG || (r_cnt[ZERO_REG_IDX] == '0));
        end
    end

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   NREGS x DATA_W register file for the decode stage: two combinational
//   read ports with write-through bypass, one synchronous write port, an
//   optional hard-wired zero register and a per-register pending-write
//   scoreboard (pending_scoreboard) that drives issue_ready and stall.
//   Ports: clk, rst_n (sync, active-low), rf (register_file_if.slave)
// ---------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int PEND_W   = DEF_PEND_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    register_file_if.slave rf
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wrAccept;

    assign w_wrAccept = rf.wr_en && !(ZERO_REG && (rf.wr_addr == ZERO_ADDR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrAccept) begin
            r_regs[rf.wr_addr] <= rf.wr_data;
        end
    end

    // Zero register takes priority over bypass so a write to r0 never leaks.
    always_comb begin
        if (ZERO_REG && (rf.rd_addr_a == ZERO_ADDR)) begin
            rf.bus_a = '0;
        end else if (rf.wr_en && (rf.wr_addr == rf.rd_addr_a)) begin
            rf.bus_a = rf.wr_data;
        end else begin
            rf.bus_a = r_regs[rf.rd_addr_a];
        end
    end

    always_comb begin
        if (ZERO_REG && (rf.rd_addr_b == ZERO_ADDR)) begin
            rf.bus_b = '0;
        end else if (rf.wr_en && (rf.wr_addr == rf.rd_addr_b)) begin
            rf.bus_b = rf.wr_data;
        end else begin
            rf.bus_b = r_regs[rf.rd_addr_b];
        end
    end

    pending_scoreboard #(
        .NREGS    (NREGS),
        .ADDR_W   (ADDR_W),
        .PEND_W   (PEND_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_en       (rf.wr_en),
        .i_wr_addr     (rf.wr_addr),
        .i_issue_en    (rf.issue_en),
        .i_issue_addr  (rf.issue_addr),
        .i_rd_addr_a   (rf.rd_addr_a),
        .i_rd_addr_b   (rf.rd_addr_b),
        .i_use_a       (rf.use_a),
        .i_use_b       (rf.use_b),
        .o_issue_ready (rf.issue_ready),
        .o_stall       (rf.stall)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(ZERO_REG && w_wrAccept && (rf.wr_addr == ZERO_ADDR)));
        end
    end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Drives register_file through directed scenarios followed by randomized
//   traffic, comparing every cycle against an array-based reference model.
// ---------------------------------------------------------------------------
module tb_register_file;
    import register_file_pkg::*;

    localparam int PMAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    register_file_if #(.DATA_W(DEF_DATA_W), .ADDR_W(DEF_ADDR_W)) rf ();

    register_file #(
        .DATA_W   (32),
        .NREGS    (32),
        .ADDR_W   (5),
        .PEND_W   (2),
        .ZERO_REG (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] mRegs [32];
    int          mCnt  [32];
    bit          modelKnown = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int ra, input int rb, input bit ua, input bit ub,
                                 input bit we, input int wa, input logic [31:0] wd,
                                 input bit ie, input int ia);
        rf.rd_addr_a  = 5'(ra);
        rf.rd_addr_b  = 5'(rb);
        rf.use_a      = ua;
        rf.use_b      = ub;
        rf.wr_en      = we;
        rf.wr_addr    = 5'(wa);
        rf.wr_data    = wd;
        rf.issue_en   = ie;
        rf.issue_addr = 5'(ia);
    endtask

    // Reference model: register 0 reads zero, then bypass, then storage.
    function automatic logic [31:0] expRead(input int addr);
        if (addr == 0) return 32'h0;
        if (rf.wr_en && int'(rf.wr_addr) == addr) return rf.wr_data;
        return mRegs[addr];
    endfunction

    function automatic bit retiring(input int addr);
        return rf.wr_en && (int'(rf.wr_addr) == addr) && (mCnt[addr] > 0);
    endfunction

    function automatic int pendEff(input int addr);
        return mCnt[addr] - (retiring(addr) ? 1 : 0);
    endfunction

    function automatic bit expStall();
        int ra = int'(rf.rd_addr_a);
        int rb = int'(rf.rd_addr_b);
        return (rf.use_a && ra != 0 && pendEff(ra) > 0) ||
               (rf.use_b && rb != 0 && pendEff(rb) > 0);
    endfunction

    function automatic bit expReady();
        int ia = int'(rf.issue_addr);
        return (mCnt[ia] < PMAX) || retiring(ia);
    endfunction

    task automatic updateModel();
        int  wa;
        int  ia;
        bit  accepted;
        bit  wasRet;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = 32'h0;
                mCnt[i]  = 0;
            end
            modelKnown = 1'b1;
            return;
        end
        wa       = int'(rf.wr_addr);
        ia       = int'(rf.issue_addr);
        accepted = rf.issue_en && expReady() && (ia != 0);
        wasRet   = retiring(wa);
        if (rf.wr_en && wa != 0) mRegs[wa] = rf.wr_data;
        if (wasRet) mCnt[wa] = mCnt[wa] - 1;
        if (accepted) mCnt[ia] = mCnt[ia] + 1;
    endtask

    // Check combinational outputs mid-cycle, then advance the model on the edge.
    task automatic stepCycle();
        @(negedge clk);
        if (modelKnown) begin
            checkOutput("bus_a", rf.bus_a, expRead(int'(rf.rd_addr_a)));
            checkOutput("bus_b", rf.bus_b, expRead(int'(rf.rd_addr_b)));
            checkOutput("stall", 32'(rf.stall), 32'(expStall()));
            checkOutput("issue_ready", 32'(rf.issue_ready), 32'(expReady()));
        end
        @(posedge clk);
        updateModel();
        #1;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        repeat (2) stepCycle();
        rst_n = 1'b1;

        // Every address reads zero after reset, nothing stalls.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(i, 31 - i, 1, 1, 0, 0, 32'h0, 0, i);
            #1;
            checkOutput("rst_bus_a", rf.bus_a, 32'h0);
            checkOutput("rst_bus_b", rf.bus_b, 32'h0);
            checkOutput("rst_stall", 32'(rf.stall), 32'h0);
            checkOutput("rst_ready", 32'(rf.issue_ready), 32'h1);
            stepCycle();
        end

        // Plain write then read-back; r0 ignores writes.
        applyStimulus(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        stepCycle();
        applyStimulus(5, 0, 0, 0, 1, 0, 32'h00001234, 0, 0);
        #1;
        checkOutput("r5_read", rf.bus_a, 32'hDEADBEEF);
        stepCycle();
        applyStimulus(0, 5, 0, 0, 0, 0, 32'h0, 0, 0);
        #1;
        checkOutput("r0_zero", rf.bus_a, 32'h0);
        stepCycle();

        // Same-cycle bypass on port B.
        applyStimulus(0, 7, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0);
        #1;
        checkOutput("bypass_b", rf.bus_b, 32'hA5A5A5A5);
        stepCycle();

        // Scoreboard: issue r3, stall while used, clear on writeback.
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1, 3);
        stepCycle();
        applyStimulus(3, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        #1;
        checkOutput("r3_stall", 32'(rf.stall), 32'h1);
        stepCycle();
        applyStimulus(3, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        #1;
        checkOutput("r3_nouse", 32'(rf.stall), 32'h0);
        stepCycle();
        applyStimulus(3, 0, 1, 0, 1, 3, 32'h33333333, 0, 0);
        #1;
        checkOutput("r3_wb_stall", 32'(rf.stall), 32'h0);
        checkOutput("r3_wb_bus", rf.bus_a, 32'h33333333);
        stepCycle();

        // Saturate r9, refuse a fourth issue, accept issue+writeback, drain.
        repeat (3) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1, 9);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1, 9);
        #1;
        checkOutput("r9_full", 32'(rf.issue_ready), 32'h0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 1, 9, 32'h99, 1, 9);
        #1;
        checkOutput("r9_swap", 32'(rf.issue_ready), 32'h1);
        stepCycle();
        applyStimulus(9, 0, 1, 0, 0, 0, 32'h0, 1, 9);
        #1;
        checkOutput("r9_still_full", 32'(rf.issue_ready), 32'h0);
        checkOutput("r9_stall", 32'(rf.stall), 32'h1);
        applyStimulus(9, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        stepCycle();
        repeat (3) begin
            applyStimulus(9, 0, 1, 0, 1, 9, $urandom, 0, 0);
            stepCycle();
        end
        applyStimulus(9, 0, 1, 0, 0, 0, 32'h0, 0, 9);
        #1;
        checkOutput("r9_drained", 32'(rf.stall), 32'h0);
        checkOutput("r9_ready", 32'(rf.issue_ready), 32'h1);
        stepCycle();

        // Reset with r4 written and two writes pending.
        applyStimulus(0, 0, 0, 0, 1, 4, 32'h44444444, 0, 0);
        stepCycle();
        repeat (2) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1, 4);
            stepCycle();
        end
        applyStimulus(0, 4, 0, 1, 0, 0, 32'h0, 0, 0);
        #1;
        checkOutput("r4_pending", 32'(rf.stall), 32'h1);
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("r4_rst_stall", 32'(rf.stall), 32'h0);
        checkOutput("r4_rst_bus", rf.bus_b, 32'h0);
        stepCycle();

        // Randomized traffic, mostly on a few registers to reach saturation.
        for (int n = 0; n < 1500; n++) begin
            int ra;
            int rb;
            int wa;
            int ia;
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 299) != 0);
            applyStimulus(ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 1)), wa, $urandom,
                          ($urandom_range(0, 9) < 6), ia);
            stepCycle();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
